// File: rtl/tmp_pkg.sv
// Shared types and default sizing for the temperature-sensor readout path.
package tmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } tmp_state_t;

    localparam int OSR_LOG2_DEF    = 8;
    localparam int SETTLE_N_DEF    = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/tmp_sync.sv
// Multi-flop synchroniser for a single asynchronous level (e.g. comparator output).
module tmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/tmp_readout.sv
// Decimates comparator decisions into a ones-count temperature code and
// presents each code on a valid/ready port with a sticky overrun flag.
module tmp_readout
    import tmp_pkg::*;
#(
    parameter int OSR_LOG2    = OSR_LOG2_DEF,
    parameter int SETTLE_N    = SETTLE_N_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              smp,
    input  logic              cmp,
    input  logic              clr_ovr,
    output logic [OSR_LOG2:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int            W           = OSR_LOG2 + 1;
    localparam logic [W-1:0]  CNT_LAST    = W'((1 << OSR_LOG2) - 1);
    localparam int            SW          = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);

    tmp_state_t    state_reg;
    logic          smp_q_reg;
    logic [W-1:0]  cnt_reg;
    logic [W-1:0]  ones_reg;
    logic [SW-1:0] settle_reg;
    logic [W-1:0]  code_reg;
    logic          code_valid_reg;
    logic          overrun_reg;

    logic          cmp_s;
    logic          ev;
    logic [W-1:0]  ones_next;
    logic          result_fire;
    logic          result_load;
    logic          result_drop;

    tmp_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cmp),
        .q       (cmp_s)
    );

    // The final decision of a conversion is folded in combinationally so the
    // code register can load on the same edge that consumes that decision.
    always_comb begin
        ev          = smp & ~smp_q_reg;
        ones_next   = ones_reg + W'(cmp_s);
        result_fire = enable && (state_reg == ACCUM) && ev && (cnt_reg == CNT_LAST);
        result_load = result_fire && (!code_valid_reg || code_ready);
        result_drop = result_fire && code_valid_reg && !code_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            smp_q_reg  <= 1'b0;
            cnt_reg    <= '0;
            ones_reg   <= '0;
            settle_reg <= '0;
        end else begin
            smp_q_reg <= smp;
            if (!enable) begin
                state_reg  <= IDLE;
                cnt_reg    <= '0;
                ones_reg   <= '0;
                settle_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        cnt_reg    <= '0;
                        ones_reg   <= '0;
                        settle_reg <= '0;
                        state_reg  <= (SETTLE_N == 0) ? ACCUM : SETTLE;
                    end
                    SETTLE: begin
                        if (ev) begin
                            if (settle_reg == SETTLE_LAST) begin
                                state_reg  <= ACCUM;
                                settle_reg <= '0;
                                cnt_reg    <= '0;
                                ones_reg   <= '0;
                            end else begin
                                settle_reg <= settle_reg + 1'b1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (ev) begin
                            if (cnt_reg == CNT_LAST) begin
                                cnt_reg  <= '0;
                                ones_reg <= '0;
                            end else begin
                                cnt_reg  <= cnt_reg + 1'b1;
                                ones_reg <= ones_next;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // A pending code survives enable drops; only a new result or acceptance moves it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (result_load) begin
                code_reg       <= ones_next;
                code_valid_reg <= 1'b1;
            end else if (code_valid_reg && code_ready) begin
                code_valid_reg <= 1'b0;
            end

            if (result_drop) begin
                overrun_reg <= 1'b1;
            end else if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign code       = code_reg;
    assign code_valid = code_valid_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule
